// File: rtl/mem_write_tracer.sv
// Write-transaction tracer: snoops the memory bus and records each write in a FIFO.
// A debounced pushbutton pops the head entry. Define TRACE_FILTER_EN to add an address-window filter.
module mem_write_tracer #(
    parameter int DEPTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       we_L,
    input  logic [15:0]                memAddr,
    input  logic [15:0]                memData,
    input  logic                       advance_L,
    input  logic                       clear,
`ifdef TRACE_FILTER_EN
    input  logic [15:0]                filterLo,
    input  logic [15:0]                filterHi,
`endif
    output logic [15:0]                traceAddr,
    output logic [15:0]                traceData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 dropCount
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SYNC_STAGES = 2;

    // ---------------- pushbutton synchronizer and debouncer ----------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   db_reg;
    logic [DCW-1:0]         dbcnt_reg;
    logic                   sync_out;
    logic                   db_flip;
    logic                   pop_fire;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync_reg[gi] <= 1'b1;
                end else if (gi == 0) begin
                    sync_reg[gi] <= advance_L;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign db_flip  = (sync_out != db_reg) && (dbcnt_reg == DCW'(DEBOUNCE_CYCLES - 1));
    // The pop happens on the same edge the debounced level falls.
    assign pop_fire = db_flip && db_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_reg    <= 1'b1;
            dbcnt_reg <= '0;
        end else if (sync_out == db_reg) begin
            dbcnt_reg <= '0;
        end else if (db_flip) begin
            db_reg    <= sync_out;
            dbcnt_reg <= '0;
        end else begin
            dbcnt_reg <= dbcnt_reg + DCW'(1);
        end
    end

    // ---------------- write-transaction detection ----------------
    logic we_prev_reg;
    logic in_range;
    logic push_req;

`ifdef TRACE_FILTER_EN
    assign in_range = (memAddr >= filterLo) && (memAddr <= filterHi);
`else
    assign in_range = 1'b1;
`endif

    assign push_req = !we_L && we_prev_reg && in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_prev_reg <= 1'b1;
        end else begin
            we_prev_reg <= we_L;
        end
    end

    // ---------------- FIFO ----------------
    logic [15:0]    addr_mem [DEPTH];
    logic [15:0]    data_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_plus1;
    logic [CW-1:0]  count_reg, count_next;
    logic [15:0]    trace_addr_reg, trace_addr_next;
    logic [15:0]    trace_data_reg, trace_data_next;
    logic           overflow_reg;
    logic [7:0]     drop_reg;
    logic           is_empty, is_full;
    logic           pop_eff, push_eff, drop_eff;

    assign is_empty     = (count_reg == '0);
    assign is_full      = (count_reg == CW'(DEPTH));
    assign rd_ptr_plus1 = rd_ptr_reg + AW'(1);

    assign pop_eff  = pop_fire && !is_empty && !clear;
    assign push_eff = push_req && (!is_full || pop_eff) && !clear;
    assign drop_eff = push_req && is_full && !pop_eff && !clear;

    always_ff @(posedge clock) begin
        if (push_eff) begin
            addr_mem[wr_ptr_reg] <= memAddr;
            data_mem[wr_ptr_reg] <= memData;
        end
    end

    // Head register: the pushed word bypasses the array when it becomes head at once.
    always_comb begin
        count_next      = count_reg;
        trace_addr_next = trace_addr_reg;
        trace_data_next = trace_data_reg;
        if (push_eff && !pop_eff) begin
            count_next = count_reg + CW'(1);
        end else if (pop_eff && !push_eff) begin
            count_next = count_reg - CW'(1);
        end
        if (pop_eff) begin
            if (count_next == '0) begin
                trace_addr_next = '0;
                trace_data_next = '0;
            end else if (count_reg == CW'(1)) begin
                trace_addr_next = memAddr;
                trace_data_next = memData;
            end else begin
                trace_addr_next = addr_mem[rd_ptr_plus1];
                trace_data_next = data_mem[rd_ptr_plus1];
            end
        end else if (push_eff && is_empty) begin
            trace_addr_next = memAddr;
            trace_data_next = memData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            trace_addr_reg <= '0;
            trace_data_reg <= '0;
            overflow_reg   <= 1'b0;
            drop_reg       <= '0;
        end else if (clear) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            trace_addr_reg <= '0;
            trace_data_reg <= '0;
            overflow_reg   <= 1'b0;
            drop_reg       <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_reg <= rd_ptr_plus1;
            end
            count_reg      <= count_next;
            trace_addr_reg <= trace_addr_next;
            trace_data_reg <= trace_data_next;
            if (drop_eff) begin
                overflow_reg <= 1'b1;
                if (drop_reg != 8'hFF) begin
                    drop_reg <= drop_reg + 8'd1;
                end
            end
        end
    end

    assign traceAddr = trace_addr_reg;
    assign traceData = trace_data_reg;
    assign count     = count_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_reg;
    assign dropCount = drop_reg;

endmodule
